// File: rtl/insn_queue.sv
// ============================================================================
// Module   : insn_queue
// Brief    : In-order (pc, instruction) FIFO that decouples fetch from decode.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module insn_queue #(
    parameter  int ADDR_W = 30,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_insn,
    input  logic              if_en,
    output logic              if_stall,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_insn,
    output logic              id_en,
    input  logic              id_stall,
    output logic [PTR_W:0]    count
);

    localparam int          c_ENTRY_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W:0]       r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_head;

    // Status is decoded from registered count only, so fetch never sees a
    // combinational path from decode's stall.
    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    assign w_push   = if_en & ~w_full & ~flush;
    assign w_pop    = ~w_empty & ~id_stall & ~flush;

    assign if_stall = w_full;
    assign id_en    = ~w_empty;
    assign count    = r_count;

    assign w_head   = r_mem[r_rd_ptr];
    assign id_pc    = w_empty ? '0 : w_head[c_ENTRY_W-1:DATA_W];
    assign id_insn  = w_empty ? '0 : w_head[DATA_W-1:0];

    // Storage carries no reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {if_pc, if_insn};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_insn_queue.sv
// ============================================================================
// Module   : tb_insn_queue
// Brief    : Directed self-checking bench for insn_queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_insn_queue;

    localparam int c_ADDR_W = 30;
    localparam int c_DATA_W = 32;
    localparam int c_DEPTH  = 4;
    localparam int c_PTR_W  = $clog2(c_DEPTH);

    logic                clk;
    logic                rst;
    logic                flush;
    logic [c_ADDR_W-1:0] if_pc;
    logic [c_DATA_W-1:0] if_insn;
    logic                if_en;
    logic                if_stall;
    logic [c_ADDR_W-1:0] id_pc;
    logic [c_DATA_W-1:0] id_insn;
    logic                id_en;
    logic                id_stall;
    logic [c_PTR_W:0]    count;

    int r_checks;
    int r_errors;

    insn_queue #(
        .ADDR_W (c_ADDR_W),
        .DATA_W (c_DATA_W),
        .DEPTH  (c_DEPTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en),
        .if_stall (if_stall),
        .id_pc    (id_pc),
        .id_insn  (id_insn),
        .id_en    (id_en),
        .id_stall (id_stall),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [c_ADDR_W-1:0] pc, input logic [c_DATA_W-1:0] insn);
        if_en   = 1'b1;
        if_pc   = pc;
        if_insn = insn;
        tick();
        if_en   = 1'b0;
    endtask

    initial begin
        r_checks = 0;
        r_errors = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        if_pc    = '0;
        if_insn  = '0;
        if_en    = 1'b0;
        id_stall = 1'b1;

        #1;
        chk("rst_count_async", count, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_count", count, 0);
        chk("rst_id_en", id_en, 0);
        chk("rst_if_stall", if_stall, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_insn", id_insn, 0);

        // Three pushes while decode stalls.
        push(30'h100, 32'hA000_0001);
        chk("lat_id_pc", id_pc, 30'h100);
        chk("lat_count", count, 1);
        push(30'h101, 32'hA000_0002);
        push(30'h102, 32'hA000_0003);
        chk("p3_count", count, 3);
        chk("p3_if_stall", if_stall, 0);
        chk("p3_id_pc", id_pc, 30'h100);
        chk("p3_id_insn", id_insn, 32'hA000_0001);

        // Fill, then a blocked fifth push.
        push(30'h103, 32'hA000_0004);
        chk("full_count", count, 4);
        chk("full_if_stall", if_stall, 1);
        push(30'h104, 32'hA000_0005);
        chk("full_blocked_count", count, 4);
        chk("full_head_pc", id_pc, 30'h100);

        // Pop while full with fetch still presenting 0x104: no push that cycle.
        if_en    = 1'b1;
        if_pc    = 30'h104;
        if_insn  = 32'hA000_0005;
        id_stall = 1'b0;
        tick();
        id_stall = 1'b1;
        chk("fullpop_count", count, 3);
        chk("fullpop_if_stall", if_stall, 0);
        chk("fullpop_id_pc", id_pc, 30'h101);
        tick();
        if_en = 1'b0;
        chk("refill_count", count, 4);

        id_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_id_pc", id_pc, 64'(30'h101 + i));
            chk("drain_id_insn", id_insn, 64'(32'hA000_0002 + i));
            tick();
        end
        chk("drain_count", count, 0);
        chk("drain_id_en", id_en, 0);
        chk("drain_id_pc_zero", id_pc, 0);

        // Streaming with decode always ready; pointers wrap past DEPTH.
        for (int i = 0; i < 10; i++) begin
            if_en   = 1'b1;
            if_pc   = 30'h200 + 30'(i);
            if_insn = 32'hB000_0000 + 32'(i);
            tick();
            chk("stream_count", count, 1);
            chk("stream_id_pc", id_pc, 64'(30'h200 + i));
            chk("stream_id_insn", id_insn, 64'(32'hB000_0000 + i));
        end
        if_en = 1'b0;
        tick();
        chk("stream_end_count", count, 0);

        // Flush with a simultaneous push.
        id_stall = 1'b1;
        push(30'h310, 32'hC000_0000);
        push(30'h311, 32'hC000_0001);
        push(30'h312, 32'hC000_0002);
        chk("pre_flush_count", count, 3);
        if_en   = 1'b1;
        if_pc   = 30'h300;
        if_insn = 32'hC000_0300;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        if_en   = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_id_en", id_en, 0);
        chk("flush_id_pc", id_pc, 0);
        push(30'h400, 32'hD000_0000);
        chk("post_flush_id_pc", id_pc, 30'h400);
        chk("post_flush_count", count, 1);

        // Empty queue ignores a ready decode stage.
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        id_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_count", count, 0);
            chk("empty_id_en", id_en, 0);
        end
        id_stall = 1'b1;
        push(30'h500, 32'hE000_0000);
        chk("empty_then_push_pc", id_pc, 30'h500);
        chk("empty_then_push_insn", id_insn, 32'hE000_0000);

        // Asynchronous reset between edges.
        push(30'h501, 32'hE000_0001);
        chk("pre_rst_count", count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_id_en", id_en, 0);
        chk("async_rst_if_stall", if_stall, 0);
        chk("async_rst_id_pc", id_pc, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_count", count, 0);
        push(30'h600, 32'hF000_0000);
        chk("post_rst_id_pc", id_pc, 30'h600);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/insn_queue.md
Name: insn_queue

Overview:
- Small instruction FIFO directly downstream of the fetch stage; decouples fetch from decode.
- Captures each fetched (pc, instruction) pair presented with if_en and presents it in order to the decode stage.
- Backpressures fetch when full and discards all contents on a pipeline flush (branch or exception redirect).

Parameters:
ADDR_W, 30, word-address width (matches WordAddr)
DATA_W, 32, instruction width (matches WordData)
DEPTH, 4, entry count; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  discard all entries and the current push
if_pc  input  ADDR_W  pc of fetched instruction
if_insn  input  DATA_W  fetched instruction
if_en  input  1  if_pc/if_insn valid this cycle
if_stall  output  1  queue full; fetch must hold its outputs
id_pc  output  ADDR_W  pc of head entry
id_insn  output  DATA_W  instruction of head entry
id_en  output  1  head entry valid
id_stall  input  1  decode not accepting this cycle
count  output  PTR_W+1  occupied entries, 0..DEPTH

Behaviour:
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0. Storage array is not reset.
  - Outputs during and after reset: id_en=0, if_stall=0, id_pc=0, id_insn=0.
- push = if_en & ~if_stall & ~flush.
- pop = id_en & ~id_stall & ~flush.
- if_stall = (count == DEPTH). Decoded from registered count only; no combinational path from id_stall.
- id_en = (count != 0).
- id_pc/id_insn = storage[rd_ptr] when id_en=1, else forced to 0. Combinational read of registered storage.
- Push: storage[wr_ptr] <= {if_pc, if_insn}; wr_ptr increments modulo DEPTH (natural wrap, PTR_W bits).
- Pop: rd_ptr increments modulo DEPTH.
- count next value:
  - +1 on push only
  - -1 on pop only
  - unchanged on push & pop
  - unchanged when neither
- Latency: entry pushed in cycle N appears at id_* in cycle N+1, including into an empty queue. There is no bypass.
- Full: if_stall=1, so a push is impossible that cycle even if a pop occurs. Full-with-pop drops to DEPTH-1 next cycle and accepts pushes again.
- Empty: id_en=0, so pop is impossible; id_stall is ignored.
- if_en=1 while full: the entry is not written. Fetch holds it under if_stall and re-presents it; no data is lost and no error is flagged.
- Flush has priority over everything:
  - Next cycle: rd_ptr=wr_ptr=0, count=0, id_en=0.
  - Same-cycle push and pop are suppressed.
  - Cycle after flush behaves as the empty queue; a push in that cycle is accepted normally.
- Flush while empty: no effect beyond pointer reset.
- Reset asserted mid-operation: immediate (async) return to reset state; all queued entries lost.
- No X propagation on id_pc/id_insn when empty (forced 0).

Test Plan:
- Reset then 3 pushes: pc 0x100/0x101/0x102 with insn 0xA0000001/2/3, id_stall=1 -> count reaches 3, if_stall=0, id_pc=0x100 held, id_insn=0xA0000001.
- Fill: 4 pushes with id_stall=1 -> count=4, if_stall=1; a 5th presented pc 0x104 is not written. Release id_stall one cycle -> 0x100 pops, count=3, if_stall=0. Next cycle 0x104 is accepted; pop order is 0x101, 0x102, 0x103, 0x104.
- Streaming: push every cycle with id_stall=0 over 10 cycles, pc 0x200..0x209 -> count stays 1 after the first cycle. id_pc lags if_pc by exactly one cycle; pointers wrap past DEPTH with no gap or duplicate.
- Flush: count=3 plus simultaneous if_en=1 (pc 0x300) and flush=1 -> next cycle count=0, id_en=0, id_pc=0; 0x300 never appears. Push 0x400 next cycle -> id_pc=0x400 one cycle later.
- Empty pop: count=0, id_stall=0, if_en=0 for 3 cycles -> count stays 0, id_en=0, pointers unchanged.
- Async reset mid-stream: count=2, rst pulsed between clock edges -> id_en=0, if_stall=0 and count=0 immediately, before the next edge.
